// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder with pipeline stall, done
//            pulse and saturating load/store access counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int AW      = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        stall,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [1:0]  c_idle     = 2'd0;
  localparam logic [1:0]  c_busy     = 2'd1;
  localparam logic [1:0]  c_done     = 2'd2;
  localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);
  localparam logic [15:0] c_sat      = 16'hFFFF;
  localparam int          c_depth    = 1 << AW;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "dmem_responder: LATENCY=%0d outside legal range 1..15", LATENCY);
    end
  endgenerate

  // Upper address bits are deliberately ignored so addresses alias modulo 2^AW.
  generate
    if (AW < 16) begin : g_addr_unused
      logic w_unused_addr;
      assign w_unused_addr = ^addr[15:AW];
    end
  endgenerate

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic          r_op_wr;
  logic [15:0]   r_mem [0:c_depth-1];

  logic w_req;
  logic w_complete;

  assign w_req      = re | we;
  assign w_complete = (r_state == c_busy) && (r_cnt == 4'd0);
  assign stall      = ((r_state == c_idle) && w_req) || (r_state == c_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= 16'd0;
      r_op_wr  <= 1'b0;
      rdata    <= 16'd0;
      done     <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      case (r_state)
        c_idle: begin
          done <= 1'b0;
          if (w_req) begin
            r_addr  <= addr[AW-1:0];
            r_wdata <= wdata;
            r_op_wr <= we;
            r_cnt   <= c_cnt_init;
            r_state <= c_busy;
          end
        end
        c_busy: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= c_done;
            done    <= 1'b1;
            if (r_op_wr) begin
              if (wr_count != c_sat) wr_count <= wr_count + 16'd1;
            end else begin
              rdata <= r_mem[r_addr];
              if (rd_count != c_sat) rd_count <= rd_count + 16'd1;
            end
          end
        end
        // The request still visible here is the one just served; ignore it.
        c_done: begin
          r_state <= c_idle;
          done    <= 1'b0;
        end
        default: begin
          r_state <= c_idle;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; an async reset forces IDLE, which cancels a pending write.
  always_ff @(posedge clk) begin
    if (w_complete && r_op_wr) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we, sel;
  logic [15:0] addr, wdata;

  logic        w_re0, w_we0, w_re1, w_we1;
  logic [15:0] w_rdata0, w_rdata1, w_rdc0, w_rdc1, w_wrc0, w_wrc1;
  logic        w_done0, w_done1, w_stall0, w_stall1;
  logic [15:0] rdata_m, rdc_m, wrc_m;
  logic        done_m, stall_m;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_wr, exp_rd;

  always #5 clk = ~clk;

  // sel routes requests and observation to the LATENCY=1 instance.
  assign w_re0   = re & ~sel;
  assign w_we0   = we & ~sel;
  assign w_re1   = re & sel;
  assign w_we1   = we & sel;
  assign rdata_m = sel ? w_rdata1 : w_rdata0;
  assign done_m  = sel ? w_done1  : w_done0;
  assign stall_m = sel ? w_stall1 : w_stall0;
  assign rdc_m   = sel ? w_rdc1   : w_rdc0;
  assign wrc_m   = sel ? w_wrc1   : w_wrc0;

  dmem_responder #(.AW(12), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(w_re0), .we(w_we0), .wdata(wdata),
    .rdata(w_rdata0), .done(w_done0), .stall(w_stall0),
    .rd_count(w_rdc0), .wr_count(w_wrc0)
  );

  dmem_responder #(.AW(12), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(w_re1), .we(w_we1), .wdata(wdata),
    .rdata(w_rdata1), .done(w_done1), .stall(w_stall1),
    .rd_count(w_rdc1), .wr_count(w_wrc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request and holds it until done; returns stall and cycle counts.
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int nstall, output int ncyc,
                        output logic stall_at_done);
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d;
    nstall = 0; ncyc = 0;
    #1;
    while (!done_m && ncyc < 40) begin
      if (stall_m) nstall++;
      ncyc++;
      @(negedge clk);
      #1;
    end
    stall_at_done = stall_m;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [15:0] a, input logic [15:0] d);
    int ns, nc; logic sd; int lat;
    lat = sel ? 2 : 3;
    access(1'b0, 1'b1, a, d, ns, nc, sd);
    if (exp_wr != 16'hFFFF) exp_wr++;
    check({tag, "_stall"}, ns, lat);
    check({tag, "_lat"}, nc, lat);
    check({tag, "_stall_done"}, sd, 0);
    check({tag, "_wr_count"}, wrc_m, exp_wr);
  endtask

  task automatic do_load(input string tag, input logic [15:0] a, input logic [15:0] exp_data);
    int ns, nc; logic sd; int lat;
    lat = sel ? 2 : 3;
    access(1'b1, 1'b0, a, 16'h0000, ns, nc, sd);
    if (exp_rd != 16'hFFFF) exp_rd++;
    check({tag, "_lat"}, nc, lat);
    check({tag, "_rdata"}, rdata_m, exp_data);
    check({tag, "_rd_count"}, rdc_m, exp_rd);
  endtask

  initial begin
    int ns, nc, npulse, t1, t2;
    logic sd;
    logic [15:0] got1, got2;

    rst_n = 1'b0; re = 1'b0; we = 1'b0; sel = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    exp_wr = 16'd0; exp_rd = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdata", rdata_m, 16'h0000);
    check("rst_done", done_m, 0);
    check("rst_stall", stall_m, 0);
    check("rst_rd_count", rdc_m, 16'h0000);
    check("rst_wr_count", wrc_m, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load
    do_store("st1", 16'h0010, 16'hBEEF);
    do_load("ld1", 16'h0010, 16'hBEEF);

    // Back-to-back loads with request held continuously
    do_store("pre1", 16'h0001, 16'h1111);
    do_store("pre2", 16'h0002, 16'h2222);
    npulse = 0; t1 = 0; t2 = 0; got1 = 16'h0000; got2 = 16'h0000;
    @(negedge clk);
    re = 1'b1; addr = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (done_m) begin
        npulse++;
        if (npulse == 1) begin
          t1 = i; got1 = rdata_m; addr = 16'h0002;
        end else begin
          t2 = i; got2 = rdata_m; re = 1'b0;
        end
      end
      @(negedge clk);
    end
    re = 1'b0;
    exp_rd = exp_rd + 16'd2;
    check("b2b_pulses", npulse, 2);
    check("b2b_first_at", t1, 3);
    check("b2b_gap", t2 - t1, 4);
    check("b2b_rdata1", got1, 16'h1111);
    check("b2b_rdata2", got2, 16'h2222);
    check("b2b_rd_count", rdc_m, exp_rd);

    // Simultaneous re and we behaves as a store
    access(1'b1, 1'b1, 16'h0005, 16'h00AA, ns, nc, sd);
    exp_wr++;
    check("rw_lat", nc, 3);
    check("rw_rdata_kept", rdata_m, 16'h2222);
    check("rw_wr_count", wrc_m, exp_wr);
    check("rw_rd_count", rdc_m, exp_rd);
    do_load("rw_ld", 16'h0005, 16'h00AA);

    // Address wrap
    do_store("wrap_st", 16'h1003, 16'h5A5A);
    do_load("wrap_ld", 16'h0003, 16'h5A5A);

    // Reset while a store is in flight
    do_store("rst_pre", 16'h0007, 16'h0000);
    @(negedge clk);
    we = 1'b1; addr = 16'h0007; wdata = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b0; we = 1'b0;
    #1;
    check("mid_rst_done", done_m, 0);
    check("mid_rst_stall", stall_m, 0);
    check("mid_rst_wr_count", wrc_m, 16'h0000);
    check("mid_rst_rdata", rdata_m, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr = 16'd0; exp_rd = 16'd0;
    do_load("mid_rst_ld", 16'h0007, 16'h0000);

    // LATENCY=1 instance: timing and counter saturation
    sel = 1'b1;
    exp_wr = 16'd0; exp_rd = 16'd0;
    do_store("l1_st", 16'h0020, 16'h0001);
    @(negedge clk);
    force u_dut1.wr_count = 16'hFFFE;
    #1;
    release u_dut1.wr_count;
    exp_wr = 16'hFFFE;
    do_store("sat_st1", 16'h0021, 16'h0002);
    do_store("sat_st2", 16'h0022, 16'h0003);
    do_load("l1_ld", 16'h0020, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
